// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared constants and types for the I/D cache-fill memory arbiter:
//   default word/line widths, line-offset width, FSM state encoding and the
//   last-grant marker used by the round-robin pick.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Default widths; the top module exposes these as overridable parameters.
    localparam int DEFAULT_WORD_SIZE  = 16;
    localparam int DEFAULT_CACHE_LINE = 64;

    // A line holds 4 words, so the low 2 address bits select a word in the line.
    localparam int LINE_WORDS       = 4;
    localparam int LINE_OFFSET_BITS = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_RD   = 3'd1,
        D_RD   = 3'd2,
        D_WR   = 3'd3,
        RESP_I = 3'd4,
        RESP_D = 3'd5
    } arb_state_t;

    // Which side received the most recent grant.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_side_t;

endpackage : mem_arbiter_pkg

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
//   Two-requester round-robin pick. A lone requester always wins; when both
//   request, the side that did not win last time is granted. Purely
//   combinational: the caller owns the last-grant register and decides when a
//   grant is actually taken.
//
//   Ports
//     req_i    in   I-side request
//     req_d    in   D-side request
//     last     in   side granted most recently
//     grant_i  out  I-side wins this pick
//     grant_d  out  D-side wins this pick
// -----------------------------------------------------------------------------
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic        req_i,
    input  logic        req_d,
    input  grant_side_t last,
    output logic        grant_i,
    output logic        grant_d
);

    // At most one grant is ever high.
    assign grant_i = req_i & (~req_d | (last == GRANT_D));
    assign grant_d = req_d & (~req_i | (last == GRANT_I));

endmodule : arb_rr2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one line-wide memory port between an instruction cache (line fills)
//   and a data cache (line fills and write-backs). One memory transaction is
//   outstanding at a time. A granted request has its address, write data and
//   direction captured, memory is asked until it acks, and the requester then
//   sees a single-cycle response (busy low) with the fill line on its data
//   output. Simultaneous I/D requests alternate round-robin, I first after
//   reset. On the D side a write-back beats a fill when both are asserted.
//
//   Ports
//     Clk, Reset_N  clock (rising edge) and asynchronous active-low reset
//     readM1        in   I-side line-fill request
//     address1      in   I-side word address
//     M1busy        out  low only in the I response cycle
//     data1         out  I-side fill line (word 0 in the top word)
//     readM2        in   D-side line-fill request
//     writeM2       in   D-side write-back request
//     address2      in   D-side word address
//     wbdata2       in   D-side write-back line
//     M2busy        out  low only in the D response cycle
//     data2         out  D-side fill line
//     mem_req       out  memory request, held until mem_ack
//     mem_we        out  memory write (1) / read (0)
//     mem_addr      out  line-aligned memory address
//     mem_wdata     out  memory write line
//     mem_rdata     in   memory read line, valid with mem_ack
//     mem_ack       in   single-cycle memory completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int CACHE_LINE = DEFAULT_CACHE_LINE
) (
    input  logic                  Clk,
    input  logic                  Reset_N,

    input  logic                  readM1,
    input  logic [WORD_SIZE-1:0]  address1,
    output logic                  M1busy,
    output logic [CACHE_LINE-1:0] data1,

    input  logic                  readM2,
    input  logic                  writeM2,
    input  logic [WORD_SIZE-1:0]  address2,
    input  logic [CACHE_LINE-1:0] wbdata2,
    output logic                  M2busy,
    output logic [CACHE_LINE-1:0] data2,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [CACHE_LINE-1:0] mem_wdata,
    input  logic [CACHE_LINE-1:0] mem_rdata,
    input  logic                  mem_ack
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    grant_side_t last_q;
    logic        grant_i;
    logic        grant_d;

    // Line-aligned views of the two request addresses.
    logic [WORD_SIZE-1:0] line_addr1;
    logic [WORD_SIZE-1:0] line_addr2;

    assign line_addr1 = {address1[WORD_SIZE-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    assign line_addr2 = {address2[WORD_SIZE-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};

    arb_rr2 u_rr2 (
        .req_i   (readM1),
        .req_d   (readM2 | writeM2),
        .last    (last_q),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of the order processes evaluate in.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        M1busy  = 1'b1;
        M2busy  = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = I_RD;
                end else if (grant_d) begin
                    state_d = writeM2 ? D_WR : D_RD;
                end
            end

            I_RD: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = RESP_I;
            end

            D_RD, D_WR: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = RESP_D;
            end

            // Response cycles always fall back to IDLE, which guarantees one
            // idle cycle so a requester can drop its request after the pulse.
            RESP_I: begin
                M1busy  = 1'b0;
                state_d = IDLE;
            end

            RESP_D: begin
                M2busy  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Grant capture: address, direction and write line are frozen at grant so
    // the memory sees a stable request even if the cache changes its inputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            last_q    <= GRANT_D;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (state_q == IDLE) begin
            if (grant_i) begin
                last_q    <= GRANT_I;
                mem_addr  <= line_addr1;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
            end else if (grant_d) begin
                last_q    <= GRANT_D;
                mem_addr  <= line_addr2;
                mem_we    <= writeM2;
                mem_wdata <= writeM2 ? wbdata2 : '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fill lines: loaded only on an ack in the matching read state, so stray
    // acks and write-back acks never disturb them.
    // -------------------------------------------------------------------------
    // NOTE: these are plain registers, not a memory array, so they take the
    // reset value the caches expect to see before their first fill.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            data1 <= '0;
            data2 <= '0;
        end else if (mem_ack) begin
            if (state_q == I_RD) data1 <= mem_rdata;
            if (state_q == D_RD) data2 <= mem_rdata;
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small memory model acks each request a
//   fixed number of cycles after mem_req rises and forgets a request whose
//   mem_req falls early. Inputs are driven and outputs sampled on the falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int W   = 16;
    localparam int CL  = 64;
    localparam int LAT = 3;

    logic          Clk;
    logic          Reset_N;
    logic          readM1;
    logic [W-1:0]  address1;
    logic          M1busy;
    logic [CL-1:0] data1;
    logic          readM2;
    logic          writeM2;
    logic [W-1:0]  address2;
    logic [CL-1:0] wbdata2;
    logic          M2busy;
    logic [CL-1:0] data2;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [CL-1:0] mem_wdata;
    logic [CL-1:0] mem_rdata;
    logic          mem_ack;

    logic          model_ack;
    logic          stray_ack;

    int n_checks = 0;
    int n_fail   = 0;

    assign mem_ack = model_ack | stray_ack;

    mem_arbiter #(
        .WORD_SIZE  (W),
        .CACHE_LINE (CL)
    ) dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .readM1    (readM1),
        .address1  (address1),
        .M1busy    (M1busy),
        .data1     (data1),
        .readM2    (readM2),
        .writeM2   (writeM2),
        .address2  (address2),
        .wbdata2   (wbdata2),
        .M2busy    (M2busy),
        .data2     (data2),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: mem_req first seen 1ns after grant edge (count 1); the
    // ack is raised in the cycle starting LAT edges later.
    initial begin
        int cnt;
        cnt       = 0;
        model_ack = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (model_ack) begin
                model_ack = 1'b0;
                cnt       = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt == LAT + 1) model_ack = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Counts falling edges until the selected busy goes low, bounded.
    task automatic wait_busy(input bit side_d, output int n);
        n = 0;
        while (((side_d ? M2busy : M1busy) !== 1'b0) && n < 20) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic apply_reset();
        Reset_N = 1'b0;
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy_lows;
        int req_highs;

        Reset_N   = 1'b0;
        readM1    = 1'b0;
        address1  = '0;
        readM2    = 1'b0;
        writeM2   = 1'b0;
        address2  = '0;
        wbdata2   = '0;
        mem_rdata = '0;
        stray_ack = 1'b0;
        repeat (3) @(negedge Clk);

        // ---- reset state ----
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", mem_wdata,      64'd0);
        check("rst_M1busy",    64'(M1busy),    64'd1);
        check("rst_M2busy",    64'(M2busy),    64'd1);
        check("rst_data1",     data1,          64'd0);
        check("rst_data2",     data2,          64'd0);
        Reset_N = 1'b1;
        @(negedge Clk);

        // ---- single I fill, latency 3 ----
        readM1    = 1'b1;
        address1  = 16'h0123;
        mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge Clk);
        check("i_mem_req",  64'(mem_req),  64'd1);
        check("i_mem_addr", 64'(mem_addr), 64'h0120);
        check("i_mem_we",   64'(mem_we),   64'd0);
        readM1 = 1'b0;
        wait_busy(1'b0, n);
        check("i_resp_delay", 64'(n), 64'd4);
        check("i_data1",      data1, 64'h1111_2222_3333_4444);
        check("i_M2busy",     64'(M2busy), 64'd1);
        @(negedge Clk);
        check("i_busy_one_cycle", 64'(M1busy), 64'd1);
        check("i_data1_hold",     data1, 64'h1111_2222_3333_4444);
        check("i_idle_req",       64'(mem_req), 64'd0);

        // ---- collisions after reset: I, then D, then I ----
        apply_reset();
        readM1    = 1'b1;
        address1  = 16'h0040;
        readM2    = 1'b1;
        address2  = 16'h0085;
        mem_rdata = 64'hAAAA_0000_AAAA_0001;
        @(negedge Clk);
        check("c1_addr_i", 64'(mem_addr), 64'h0040);
        check("c1_we",     64'(mem_we),   64'd0);
        wait_busy(1'b0, n);
        check("c1_resp_delay", 64'(n), 64'd4);
        check("c1_data1",      data1, 64'hAAAA_0000_AAAA_0001);
        mem_rdata = 64'hBBBB_0000_BBBB_0002;
        @(negedge Clk);
        check("c2_idle_req", 64'(mem_req), 64'd0);
        @(negedge Clk);
        check("c2_req",    64'(mem_req),  64'd1);
        check("c2_addr_d", 64'(mem_addr), 64'h0084);
        wait_busy(1'b1, n);
        check("c2_resp_delay", 64'(n), 64'd4);
        check("c2_data2",      data2, 64'hBBBB_0000_BBBB_0002);
        check("c2_data1_hold", data1, 64'hAAAA_0000_AAAA_0001);
        mem_rdata = 64'hCCCC_0000_CCCC_0003;
        @(negedge Clk);
        @(negedge Clk);
        check("c3_addr_i", 64'(mem_addr), 64'h0040);
        readM1 = 1'b0;
        readM2 = 1'b0;
        wait_busy(1'b0, n);
        check("c3_resp_delay", 64'(n), 64'd4);
        check("c3_data1",      data1, 64'hCCCC_0000_CCCC_0003);
        @(negedge Clk);

        // ---- D write-back beats D read; then the read follows ----
        writeM2   = 1'b1;
        readM2    = 1'b1;
        address2  = 16'h00F7;
        wbdata2   = 64'hDEAD_BEEF_0000_0001;
        mem_rdata = 64'h5555_5555_5555_5555;
        @(negedge Clk);
        check("wb_req",   64'(mem_req),  64'd1);
        check("wb_we",    64'(mem_we),   64'd1);
        check("wb_addr",  64'(mem_addr), 64'h00F4);
        check("wb_wdata", mem_wdata,     64'hDEAD_BEEF_0000_0001);
        writeM2  = 1'b0;
        address2 = 16'h1237;
        wbdata2  = 64'h0;
        wait_busy(1'b1, n);
        check("wb_resp_delay", 64'(n), 64'd4);
        check("wb_addr_held",  64'(mem_addr), 64'h00F4);
        check("wb_wdata_held", mem_wdata,     64'hDEAD_BEEF_0000_0001);
        check("wb_data2_kept", data2,         64'hBBBB_0000_BBBB_0002);
        @(negedge Clk);
        check("wb_idle_req", 64'(mem_req), 64'd0);
        @(negedge Clk);
        check("rd_after_wb_we",   64'(mem_we),   64'd0);
        check("rd_after_wb_addr", 64'(mem_addr), 64'h1234);
        readM2    = 1'b0;
        mem_rdata = 64'h6666_7777_8888_9999;
        wait_busy(1'b1, n);
        check("rd_after_wb_delay", 64'(n), 64'd4);
        check("rd_after_wb_data2", data2, 64'h6666_7777_8888_9999);
        @(negedge Clk);

        // ---- reset during D_RD, one cycle before the ack ----
        readM2    = 1'b1;
        address2  = 16'h0200;
        mem_rdata = 64'h7777_7777_7777_7777;
        @(negedge Clk);
        check("rst_mid_req_before", 64'(mem_req), 64'd1);
        readM2 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b0;
        #1;
        check("rst_mid_req_drop", 64'(mem_req), 64'd0);
        check("rst_mid_data2",    data2,        64'd0);
        @(negedge Clk);
        Reset_N   = 1'b1;
        busy_lows = 0;
        req_highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (M2busy === 1'b0) busy_lows++;
            if (mem_req === 1'b1) req_highs++;
        end
        check("rst_mid_no_resp", 64'(busy_lows), 64'd0);
        check("rst_mid_idle",    64'(req_highs), 64'd0);

        // ---- I request withdrawn during I_RD ----
        readM1    = 1'b1;
        address1  = 16'h0301;
        mem_rdata = 64'h0303_0303_0303_0303;
        @(negedge Clk);
        readM1 = 1'b0;
        @(negedge Clk);
        check("wd_req_held1", 64'(mem_req), 64'd1);
        @(negedge Clk);
        check("wd_req_held2", 64'(mem_req), 64'd1);
        wait_busy(1'b0, n);
        check("wd_resp_delay", 64'(n), 64'd2);
        check("wd_data1",      data1, 64'h0303_0303_0303_0303);
        @(negedge Clk);
        check("wd_busy_back", 64'(M1busy),  64'd1);
        check("wd_idle_req",  64'(mem_req), 64'd0);
        @(negedge Clk);
        check("wd_stay_idle", 64'(mem_req), 64'd0);

        // ---- stray ack in IDLE ----
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        stray_ack = 1'b1;
        @(negedge Clk);
        stray_ack = 1'b0;
        @(negedge Clk);
        check("stray_data1",  data1,          64'h0303_0303_0303_0303);
        check("stray_data2",  data2,          64'd0);
        check("stray_M1busy", 64'(M1busy),    64'd1);
        check("stray_M2busy", 64'(M2busy),    64'd1);
        check("stray_req",    64'(mem_req),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, word and address width in bits.
REQ-002 Parameter CACHE_LINE, default 64, line width in bits (4 words).
REQ-003 Port Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port Reset_N  input  1  reset, asynchronous, active-low.
REQ-005 Port readM1  input  1  I-side line-fill request.
REQ-006 Port address1  input  WORD_SIZE  I-side word address.
REQ-007 Port M1busy  output  1  I-side busy; low only during the I response cycle.
REQ-008 Port data1  output  CACHE_LINE  I-side fill line, word 0 in [63:48].
REQ-009 Port readM2  input  1  D-side line-fill request.
REQ-010 Port writeM2  input  1  D-side write-back request.
REQ-011 Port address2  input  WORD_SIZE  D-side word address.
REQ-012 Port wbdata2  input  CACHE_LINE  D-side write-back line.
REQ-013 Port M2busy  output  1  D-side busy; low only during the D response cycle.
REQ-014 Port data2  output  CACHE_LINE  D-side fill line.
REQ-015 Port mem_req  output  1  memory request, held until mem_ack.
REQ-016 Port mem_we  output  1  memory write when high, read when low.
REQ-017 Port mem_addr  output  WORD_SIZE  line-aligned address, low 2 bits forced to 0.
REQ-018 Port mem_wdata  output  CACHE_LINE  write line.
REQ-019 Port mem_rdata  input  CACHE_LINE  read line, valid in the mem_ack cycle.
REQ-020 Port mem_ack  input  1  one-cycle completion pulse; latency >= 1 cycle after mem_req rises.

Function
REQ-021 FSM states: IDLE, I_RD, D_RD, D_WR, RESP_I, RESP_D.
REQ-022 IDLE: no request -> stay; a request is sampled on the rising edge and the granted state is entered on that same edge.
REQ-023 D-side request = readM2 | writeM2; writeM2 has priority over readM2 when both are high (D_WR selected).
REQ-024 I and D both pending in IDLE: round-robin. Grant the side not granted last; the last-grant flag resets to D, so I wins first.
REQ-025 Address, write data and mem_we are latched at grant and held constant until mem_ack; later input changes are ignored.
REQ-026 I_RD, D_RD, D_WR: mem_req = 1. On mem_ack go to RESP_I or RESP_D and register mem_rdata into data1 or data2. D_WR does not update data2.
REQ-027 RESP_I / RESP_D last exactly 1 cycle. In that cycle M1busy (or M2busy) = 0 and the data output is stable. Next state is always IDLE.
REQ-028 Minimum turnaround is one IDLE cycle between transactions, so the requester can drop its request after capture.
REQ-029 mem_req = 0 in IDLE and RESP states; at most one memory transaction is outstanding.
REQ-030 Request withdrawn mid-transaction: the memory transaction completes and the response pulse is still issued.
REQ-031 mem_ack outside I_RD, D_RD or D_WR is ignored.
REQ-032 data1 and data2 hold their last values until overwritten by a later fill.

Reset
REQ-033 Reset_N low asynchronously forces: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, M1busy 1, M2busy 1, data1 0, data2 0, last-grant D.
REQ-034 Reset mid-transaction abandons it with no response pulse. The memory model drops a request whose mem_req falls before ack.

Structure
REQ-035 WORD_SIZE, CACHE_LINE and the state encodings belong in the shared opcodes include, not local defines.
REQ-036 One sub-module, arb_rr2, provides the 2-requester round-robin pick (inputs req_i, req_d, last; outputs grant_i, grant_d). The FSM stays in mem_arbiter.

Verification
REQ-037 Memory latency 3, readM1=1, address1=16'h0123 -> mem_addr=16'h0120 and mem_we=0. With mem_rdata=64'h1111_2222_3333_4444, M1busy is low for exactly 1 cycle, 4 cycles after grant, with data1 = 64'h1111_2222_3333_4444.
REQ-038 readM1 and readM2 rise on the same edge after reset -> I granted first, D granted after RESP_I plus one IDLE cycle. A repeat of the same collision grants D first.
REQ-039 writeM2=1, readM2=1, address2=16'h00F7, wbdata2=64'hDEAD_BEEF_0000_0001 -> mem_we=1, mem_addr=16'h00F4, mem_wdata as given, M2busy low for 1 cycle. The next transaction is D_RD after writeM2 drops.
REQ-040 Reset_N pulsed low in D_RD, 1 cycle before mem_ack -> mem_req=0 immediately, no M2busy low pulse, FSM returns to IDLE.
REQ-041 readM1 dropped during I_RD -> mem_req stays high until mem_ack, M1busy still pulses low once, then IDLE.
REQ-042 Stray mem_ack in IDLE -> data1, data2 and all busy outputs unchanged.
